// File: rtl/audio_rate_pkg.sv
// Shared playback-rate constants and handshake state type, common to the speed
// controller and the sample tick generator so both ends agree on divisor limits.
package audio_rate_pkg;

    localparam int unsigned DEF_DIV = 2273;
    localparam int unsigned MIN_DIV = 1136;
    localparam int unsigned MAX_DIV = 12600;

    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } hs_state_e;

endpackage

// File: rtl/sample_tick_gen_if.sv
// Tick / request / acknowledge handshake between the tick generator (master)
// and the audio sample reader (slave).
interface sample_tick_gen_if;

    logic sample_tick;
    logic sample_req;
    logic sample_ack;

    modport master (
        output sample_tick,
        output sample_req,
        input  sample_ack
    );

    modport slave (
        input  sample_tick,
        input  sample_req,
        output sample_ack
    );

endinterface

// File: rtl/rate_clamp.sv
// Registers the requested divisor every cycle, clamped to the accepted
// [MIN_DIV, MAX_DIV] range using an unsigned full-width compare.
module rate_clamp
    import audio_rate_pkg::*;
#(
    parameter int unsigned DIV_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [DIV_W-1:0] speed_i,
    output logic [DIV_W-1:0] div_o
);

    localparam logic [DIV_W-1:0] LO_DIV  = DIV_W'(MIN_DIV);
    localparam logic [DIV_W-1:0] HI_DIV  = DIV_W'(MAX_DIV);
    localparam logic [DIV_W-1:0] RST_DIV = DIV_W'(DEF_DIV);

    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] div_d;

    always_comb begin
        div_d = speed_i;
        if (speed_i < LO_DIV) begin
            div_d = LO_DIV;
        end else if (speed_i > HI_DIV) begin
            div_d = HI_DIV;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_q <= RST_DIV;
        end else begin
            div_q <= div_d;
        end
    end

    assign div_o = div_q;

endmodule

// File: rtl/sample_tick_gen.sv
// Divides clk down to one sample_tick per period of the active divisor and
// runs a req/ack handshake to the sample reader, counting overruns.
module sample_tick_gen
    import audio_rate_pkg::*;
#(
    parameter int unsigned DIV_W = 32,
    parameter int unsigned OVR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DIV_W-1:0]  speed_freq,
    input  logic              enable,
    sample_tick_gen_if.master hs,
    output logic [DIV_W-1:0]  active_div,
    output logic              overrun,
    output logic [OVR_W-1:0]  overrun_cnt
);

    localparam logic [DIV_W-1:0] RST_DIV = DIV_W'(DEF_DIV);

    logic [DIV_W-1:0] clamp_div;
    logic [DIV_W-1:0] cnt_q,        cnt_d;
    logic [DIV_W-1:0] active_div_q, active_div_d;
    logic             tick_q,       tick_d;
    logic             overrun_q,    overrun_d;
    logic [OVR_W-1:0] ovr_cnt_q,    ovr_cnt_d;
    hs_state_e        state_q,      state_d;
    logic             wrap;

    rate_clamp #(
        .DIV_W (DIV_W)
    ) u_clamp (
        .clk     (clk),
        .rst     (rst),
        .speed_i (speed_freq),
        .div_o   (clamp_div)
    );

    // The last cycle of a period; the tick, the new divisor and the
    // handshake decision all take effect on the edge that ends it.
    assign wrap = enable && (cnt_q == active_div_q - DIV_W'(1));

    always_comb begin
        cnt_d        = cnt_q;
        active_div_d = active_div_q;
        tick_d       = 1'b0;
        if (wrap) begin
            cnt_d        = '0;
            tick_d       = 1'b1;
            active_div_d = clamp_div;
        end else if (enable) begin
            cnt_d = cnt_q + DIV_W'(1);
        end
    end

    always_comb begin
        state_d   = state_q;
        overrun_d = 1'b0;
        ovr_cnt_d = ovr_cnt_q;
        case (state_q)
            IDLE: begin
                if (wrap) begin
                    state_d = REQ;
                end
            end
            REQ: begin
                if (wrap) begin
                    if (!hs.sample_ack) begin
                        overrun_d = 1'b1;
                        if (ovr_cnt_q != '1) begin
                            ovr_cnt_d = ovr_cnt_q + OVR_W'(1);
                        end
                    end
                end else if (hs.sample_ack) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q        <= '0;
            active_div_q <= RST_DIV;
            tick_q       <= 1'b0;
            overrun_q    <= 1'b0;
            ovr_cnt_q    <= '0;
            state_q      <= IDLE;
        end else begin
            cnt_q        <= cnt_d;
            active_div_q <= active_div_d;
            tick_q       <= tick_d;
            overrun_q    <= overrun_d;
            ovr_cnt_q    <= ovr_cnt_d;
            state_q      <= state_d;
        end
    end

    assign hs.sample_tick = tick_q;
    assign hs.sample_req  = (state_q == REQ);
    assign active_div     = active_div_q;
    assign overrun        = overrun_q;
    assign overrun_cnt    = ovr_cnt_q;

endmodule

// File: tb/tb_sample_tick_gen.sv
// Directed bench for sample_tick_gen: a divisor table plus hand-written
// handshake, overrun, enable-freeze and reset sequences.
module tb_sample_tick_gen;

    typedef struct {
        logic [31:0] speed;
        logic [31:0] expDiv;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] speedFreq;
    logic        enable;
    logic [31:0] activeDiv;
    logic        overrun;
    logic [7:0]  overrunCnt;
    logic        autoAck   = 1'b0;
    logic        ackAuto   = 1'b0;
    logic        ackManual = 1'b0;

    int nChecks = 0;
    int nFails  = 0;

    vec_t vecs [9];

    sample_tick_gen_if hsIf ();

    sample_tick_gen #(
        .DIV_W (32),
        .OVR_W (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .speed_freq  (speedFreq),
        .enable      (enable),
        .hs          (hsIf),
        .active_div  (activeDiv),
        .overrun     (overrun),
        .overrun_cnt (overrunCnt)
    );

    always #10 clk = ~clk;

    assign hsIf.sample_ack = autoAck ? ackAuto : ackManual;

    // Reader model: acknowledge each pending request one cycle after seeing it.
    always @(negedge clk) begin
        ackAuto = autoAck && hsIf.sample_req && !ackAuto;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        nChecks++;
        if (actual !== expected) begin
            nFails++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [31:0] speed, input logic en);
        speedFreq = speed;
        enable    = en;
    endtask

    task automatic waitTick(input int limit, output int cycles, output int reqLow);
        cycles = 0;
        reqLow = 0;
        do begin
            @(negedge clk);
            cycles++;
            if (hsIf.sample_req !== 1'b1) reqLow++;
        end while (hsIf.sample_tick !== 1'b1 && cycles < limit);
        if (hsIf.sample_tick !== 1'b1) begin
            nChecks++;
            nFails++;
            $display("[TB] FAIL tick timeout: no tick within %0d cycles", limit);
        end
    endtask

    initial begin
        int cyc;
        int rl;
        int prevDiv;
        int tickSeen;

        vecs[0] = '{32'd2273,        32'd2273};
        vecs[1] = '{32'd1136,        32'd1136};
        vecs[2] = '{32'd1135,        32'd1136};
        vecs[3] = '{32'd100,         32'd1136};
        vecs[4] = '{32'd0,           32'd1136};
        vecs[5] = '{32'd5000,        32'd5000};
        vecs[6] = '{32'd12601,       32'd12600};
        vecs[7] = '{32'd20000,       32'd12600};
        vecs[8] = '{32'd2273,        32'd2273};

        rst = 1'b1;
        applyStimulus(32'd2273, 1'b1);
        repeat (3) @(negedge clk);
        checkOutput("reset req",         32'(hsIf.sample_req),  0);
        checkOutput("reset tick",        32'(hsIf.sample_tick), 0);
        checkOutput("reset active_div",  activeDiv,             2273);
        checkOutput("reset overrun",     32'(overrun),          0);
        checkOutput("reset overrun_cnt", 32'(overrunCnt),       0);

        // Basic rate with a well-behaved reader.
        rst = 1'b0;
        waitTick(3000, cyc, rl);
        checkOutput("first tick latency", cyc, 2273);
        checkOutput("first tick req",     32'(hsIf.sample_req), 1);
        checkOutput("first tick overrun", 32'(overrun),         0);
        autoAck = 1'b1;
        waitTick(3000, cyc, rl);
        checkOutput("steady spacing",     cyc, 2273);
        checkOutput("steady overrun_cnt", 32'(overrunCnt), 0);

        // Divisor change mid-period only lands on the next boundary.
        repeat (500) @(negedge clk);
        applyStimulus(32'd1136, 1'b1);
        repeat (2) @(negedge clk);
        checkOutput("midperiod active_div", activeDiv, 2273);
        waitTick(3000, cyc, rl);
        checkOutput("midperiod remainder",  cyc, 2273 - 502);
        checkOutput("new active_div",       activeDiv, 1136);
        waitTick(3000, cyc, rl);
        checkOutput("fast spacing",         cyc, 1136);

        // Clamp table: each row loads on the next tick, spacing follows the previous row.
        prevDiv = 1136;
        for (int i = 0; i < 9; i++) begin
            applyStimulus(vecs[i].speed, 1'b1);
            waitTick(14000, cyc, rl);
            checkOutput($sformatf("vec%0d spacing", i), cyc, prevDiv);
            checkOutput($sformatf("vec%0d active_div", i), activeDiv, vecs[i].expDiv);
            prevDiv = int'(vecs[i].expDiv);
        end
        checkOutput("table overrun_cnt", 32'(overrunCnt), 0);

        // Reader stalls across three ticks.
        repeat (3) @(negedge clk);
        autoAck = 1'b0;
        checkOutput("stall idle req", 32'(hsIf.sample_req), 0);
        waitTick(3000, cyc, rl);
        checkOutput("stall tick1 req",     32'(hsIf.sample_req), 1);
        checkOutput("stall tick1 overrun", 32'(overrun),         0);
        waitTick(3000, cyc, rl);
        checkOutput("stall tick2 overrun", 32'(overrun),    1);
        checkOutput("stall tick2 cnt",     32'(overrunCnt), 1);
        checkOutput("stall tick2 req low", rl,              0);
        waitTick(3000, cyc, rl);
        checkOutput("stall tick3 overrun", 32'(overrun),    1);
        checkOutput("stall tick3 cnt",     32'(overrunCnt), 2);
        checkOutput("stall tick3 req low", rl,              0);
        @(negedge clk);
        checkOutput("overrun pulse width", 32'(overrun),         0);
        checkOutput("stall req held",      32'(hsIf.sample_req), 1);
        ackManual = 1'b1;
        @(negedge clk);
        ackManual = 1'b0;
        checkOutput("stall ack drops req", 32'(hsIf.sample_req), 0);
        checkOutput("stall cnt kept",      32'(overrunCnt),      2);

        // Ack lands on the same edge that issues the next tick.
        waitTick(3000, cyc, rl);
        repeat (2272) @(negedge clk);
        ackManual = 1'b1;
        @(negedge clk);
        ackManual = 1'b0;
        checkOutput("coincide tick",        32'(hsIf.sample_tick), 1);
        checkOutput("coincide req",         32'(hsIf.sample_req),  1);
        checkOutput("coincide overrun",     32'(overrun),          0);
        checkOutput("coincide overrun_cnt", 32'(overrunCnt),       2);
        @(negedge clk);
        checkOutput("coincide req held",    32'(hsIf.sample_req),  1);
        ackManual = 1'b1;
        @(negedge clk);
        ackManual = 1'b0;
        checkOutput("coincide later ack",   32'(hsIf.sample_req),  0);

        // Freeze the counter mid-period while the handshake still completes.
        waitTick(3000, cyc, rl);
        checkOutput("spacing after coincide", cyc, 2271);
        repeat (1000) @(negedge clk);
        applyStimulus(32'd2273, 1'b0);
        tickSeen = 0;
        for (int i = 0; i < 5000; i++) begin
            @(negedge clk);
            if (hsIf.sample_tick === 1'b1) tickSeen++;
            if (i == 99)  checkOutput("frozen req pending", 32'(hsIf.sample_req), 1);
            if (i == 100) ackManual = 1'b1;
            if (i == 101) ackManual = 1'b0;
            if (i == 102) checkOutput("frozen ack completes", 32'(hsIf.sample_req), 0);
        end
        checkOutput("frozen ticks",      tickSeen,  0);
        checkOutput("frozen active_div", activeDiv, 2273);
        applyStimulus(32'd2273, 1'b1);
        waitTick(3000, cyc, rl);
        checkOutput("resume latency", cyc, 1273);
        checkOutput("resume req",     32'(hsIf.sample_req), 1);

        // Reset in the middle of a handshake.
        repeat (10) @(negedge clk);
        checkOutput("pre-reset req", 32'(hsIf.sample_req), 1);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("midreset req",         32'(hsIf.sample_req),  0);
        checkOutput("midreset overrun_cnt", 32'(overrunCnt),       0);
        checkOutput("midreset tick",        32'(hsIf.sample_tick), 0);
        rst = 1'b0;
        waitTick(3000, cyc, rl);
        checkOutput("post-reset latency", cyc, 2273);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
